dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the pipeline MEM stage and an aux port.
// The core has priority. A starvation counter forces an aux grant after STARVE_LIM denied cycles.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic                  core_stall,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_rvalid,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [DM_ADDRESS-1:0] aux_addr,
  input  logic [DATA_W-1:0]     aux_wdata,
  input  logic [2:0]            aux_funct3,
  output logic                  aux_gnt,
  output logic [DATA_W-1:0]     aux_rdata,
  output logic                  aux_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic              w_coreActive;
  logic              w_coreRead;
  logic              w_starved;
  logic              w_grantAux;
  logic              w_grantCore;
  logic [SW-1:0]     r_starveCnt;
  logic              r_pendCore;
  logic              r_pendAux;
  logic [DATA_W-1:0] r_coreHold;
  logic [DATA_W-1:0] r_auxHold;

  // A simultaneous read+write from the core is a write; reset masks every grant.
  assign w_coreActive = core_rd | core_wr;
  assign w_coreRead   = core_rd & ~core_wr;
  assign w_starved    = (r_starveCnt == STARVE_MAX);
  assign w_grantAux   = ~reset & aux_req & (~w_coreActive | w_starved);
  assign w_grantCore  = ~reset & w_coreActive & ~w_grantAux;

  assign core_stall = ~reset & w_coreActive & ~w_grantCore;
  assign aux_gnt    = w_grantAux;

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = '0;
    if (w_grantAux) begin
      mem_rd     = ~aux_we;
      mem_wr     = aux_we;
      mem_addr   = aux_addr;
      mem_wdata  = aux_wdata;
      mem_funct3 = aux_funct3;
    end else if (w_grantCore) begin
      mem_rd     = w_coreRead;
      mem_wr     = core_wr;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_funct3 = core_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starveCnt <= '0;
    end else if (!aux_req || w_grantAux) begin
      r_starveCnt <= '0;
    end else if (!w_starved) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  // Owner flags record who issued last cycle's read so mem_rdata is steered to them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pendCore <= 1'b0;
      r_pendAux  <= 1'b0;
      r_coreHold <= '0;
      r_auxHold  <= '0;
    end else begin
      r_pendCore <= w_grantCore & w_coreRead;
      r_pendAux  <= w_grantAux & ~aux_we;
      if (r_pendCore) r_coreHold <= mem_rdata;
      if (r_pendAux)  r_auxHold  <= mem_rdata;
    end
  end

  assign core_rvalid = ~reset & r_pendCore;
  assign aux_rvalid  = ~reset & r_pendAux;
  assign core_rdata  = reset ? '0 : (r_pendCore ? mem_rdata : r_coreHold);
  assign aux_rdata   = reset ? '0 : (r_pendAux ? mem_rdata : r_auxHold);

endmodule
